apb_master_queue: RTL and testbench

Per-master request queue sitting directly upstream of `apb_interconnect`, one instance per master port. Accepts write requests (data + destination address) through a valid/ready handshake, buffers them in a FIFO, and presents them to the interconnect as single-cycle `master_valid` pulses with data/address held stable. Consecutive pulses are spaced by a programmable gap so that each transfer completes inside the interconnect before the next is issued.

---
 rtl/apb_master_queue.sv | 205 ++++++++++++++++++++
 tb/tb_apb_master_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_queue.sv
// apb_master_queue: per-master write-request FIFO that issues spaced single-cycle pulses to apb_interconnect.
// Optional feature: define APB_QUEUE_ADDR_CHECK_EN to drop and count requests addressed at or beyond NUM_SOURCES.
module apb_master_queue #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_SOURCES = 4,
    parameter int DEPTH       = 8,
    parameter int GAP_CYCLES  = 40
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic                       master_valid,
    output logic [DATA_WIDTH-1:0]      master_data,
    output logic [ADDR_WIDTH-1:0]      dest_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       addr_err,
    output logic [7:0]                 err_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

`ifdef APB_QUEUE_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [ENTRY_W-1:0]   mem_r [DEPTH];
    logic [ENTRY_W-1:0]   head_s;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic                 empty_r;
    logic                 full_r;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic                 gap_load_s;
    logic                 gap_dec_s;
    logic                 master_valid_r;
    logic [DATA_WIDTH-1:0] master_data_r;
    logic [ADDR_WIDTH-1:0] dest_addr_r;
    logic                 push_s;
    logic                 addr_ok_s;
    logic                 enq_s;
    logic                 pop_s;

    // Handshake completes whenever not full; out-of-range requests are swallowed only in the checking build.
    assign push_s    = wr_valid && !full_r;
    assign addr_ok_s = !ADDR_CHECK || (32'(wr_addr) < NUM_SOURCES);
    assign enq_s     = push_s && addr_ok_s;
    assign head_s    = mem_r[rd_ptr_r];

    // Next-state and control decode for the issue sequencer.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        gap_load_s   = 1'b0;
        gap_dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    state_next_s = ST_ISSUE;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_GAP;
                gap_load_s   = 1'b1;
            end
            ST_GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    if (!empty_r) begin
                        state_next_s = ST_ISSUE;
                        pop_s        = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    gap_dec_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy update; a push and a pop on the same edge cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Sequencer state, gap timer and issue pulse.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            gap_cnt_r      <= {GAP_W{1'b0}};
            master_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            master_valid_r <= (state_next_s == ST_ISSUE);
            if (gap_load_s) begin
                gap_cnt_r <= GAP_W'(GAP_CYCLES - 1);
            end else if (gap_dec_s) begin
                gap_cnt_r <= gap_cnt_r - GAP_W'(1);
            end
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CNT_W{1'b0}});
            full_r  <= (count_next_s == CNT_W'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge pclk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= {wr_addr, wr_data};
        end
    end

    // Payload presented to the interconnect changes only on the edge entering ISSUE.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            master_data_r <= {DATA_WIDTH{1'b0}};
            dest_addr_r   <= {ADDR_WIDTH{1'b0}};
        end else if (pop_s) begin
            master_data_r <= head_s[DATA_WIDTH-1:0];
            dest_addr_r   <= head_s[ENTRY_W-1:DATA_WIDTH];
        end
    end

`ifdef APB_QUEUE_ADDR_CHECK_EN
    logic       addr_err_r;
    logic [7:0] err_count_r;

    // Rejected-request pulse and saturating error tally.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            addr_err_r  <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            addr_err_r <= push_s && !addr_ok_s;
            if (push_s && !addr_ok_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'h01;
            end
        end
    end

    assign addr_err  = addr_err_r;
    assign err_count = err_count_r;
`else
    assign addr_err  = 1'b0;
    assign err_count = 8'h00;
`endif

    assign wr_ready     = !full_r;
    assign master_valid = master_valid_r;
    assign master_data  = master_data_r;
    assign dest_addr    = dest_addr_r;
    assign count        = count_r;
    assign empty        = empty_r;
    assign full         = full_r;

endmodule

// File: tb/tb_apb_master_queue.sv
// Self-checking bench for apb_master_queue: scoreboard of expected issues plus directed timing checks.
module tb_apb_master_queue;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int GAP = 40;

    logic          pclk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          master_valid;
    logic [DW-1:0] master_data;
    logic [AW-1:0] dest_addr;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          addr_err;
    logic [7:0]    err_count;

    apb_master_queue #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_SOURCES(4),
        .DEPTH      (8),
        .GAP_CYCLES (GAP)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .master_valid(master_valid),
        .master_data (master_data),
        .dest_addr   (dest_addr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .addr_err    (addr_err),
        .err_count   (err_count)
    );

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                prev_cyc = 0;
    int                last_pulse_cyc = 0;
    bit                have_prev = 1'b0;
    bit                spacing_en = 1'b0;
    logic [AW+DW-1:0]  sb[$];
    logic [AW+DW-1:0]  exp_e;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every issue pulse must match the oldest expected request.
    always @(negedge pclk) begin
        if (!reset && master_valid) begin
            if (sb.size() == 0) begin
                check("unexp_pulse", 64'(master_valid), 64'd0);
            end else begin
                exp_e = sb.pop_front();
                check("pulse_data", 64'(master_data), 64'(exp_e[DW-1:0]));
                check("pulse_addr", 64'(dest_addr), 64'(exp_e[AW+DW-1:DW]));
            end
            if (spacing_en && have_prev) begin
                check("spacing", 64'(cyc - prev_cyc), 64'(GAP + 1));
            end
            prev_cyc       = cyc;
            last_pulse_cyc = cyc;
            have_prev      = 1'b1;
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit issues);
        int n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("push_ready", 64'(wr_ready), 64'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_addr  = a;
        if (issues) sb.push_back({a, d});
        @(negedge pclk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!master_valid && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("pulse_seen", 64'(master_valid), 64'd1);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        repeat (GAP + 5) @(negedge pclk);
        spacing_en = 1'b0;
        check("drain_count", 64'(count), 64'd0);
        check("drain_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_addr  = '0;
        repeat (2) @(negedge pclk);
        check("rst_mv", 64'(master_valid), 64'd0);
        check("rst_data", 64'(master_data), 64'd0);
        check("rst_addr", 64'(dest_addr), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_aerr", 64'(addr_err), 64'd0);
        check("rst_ecnt", 64'(err_count), 64'd0);
        reset = 1'b0;
        @(negedge pclk);

        // Single request latency and hold.
        push(32'hDEADBEEF, 6'd2, 1'b1);
        check("lat_n_mv", 64'(master_valid), 64'd0);
        check("lat_n_count", 64'(count), 64'd1);
        @(negedge pclk);
        check("lat_mv", 64'(master_valid), 64'd1);
        check("lat_count", 64'(count), 64'd0);
        check("lat_empty", 64'(empty), 64'd1);
        @(negedge pclk);
        check("hold_mv", 64'(master_valid), 64'd0);
        check("hold_data", 64'(master_data), 64'hDEADBEEF);
        check("hold_addr", 64'(dest_addr), 64'd2);
        repeat (GAP + 5) @(negedge pclk);

        // Fill during a gap, stall the ninth offer, then drain in order with fixed spacing.
        push(32'h1000_0000, 6'd1, 1'b1);
        wait_pulse();
        spacing_en = 1'b1;
        for (int i = 0; i < 8; i++) push(32'hA000_0000 + 32'(i), 6'(i % 4), 1'b1);
        check("fill_full", 64'(full), 64'd1);
        check("fill_ready", 64'(wr_ready), 64'd0);
        check("fill_count", 64'(count), 64'd8);
        wr_valid = 1'b1;
        wr_data  = 32'hA000_0008;
        wr_addr  = 6'd0;
        repeat (3) begin
            @(negedge pclk);
            check("stall_count", 64'(count), 64'd8);
            check("stall_ready", 64'(wr_ready), 64'd0);
        end
        push(32'hA000_0008, 6'd0, 1'b1);
        wait_drain();

        // Reset during the gap discards the queued entries.
        push(32'hB000_0001, 6'd1, 1'b1);
        push(32'hB000_0002, 6'd2, 1'b0);
        push(32'hB000_0003, 6'd3, 1'b0);
        repeat (5) @(negedge pclk);
        check("pre_rst_count", 64'(count), 64'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_mv", 64'(master_valid), 64'd0);
        check("mid_rst_data", 64'(master_data), 64'd0);
        check("mid_rst_addr", 64'(dest_addr), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_sb", 64'(sb.size()), 64'd0);
        @(negedge pclk);
        reset = 1'b0;
        repeat (100) @(negedge pclk);
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_mv", 64'(master_valid), 64'd0);

        // Push coinciding with a pop at count 3, then 20 entries through pointer wrap.
        push(32'hC000_0000, 6'd0, 1'b1);
        for (int i = 1; i < 4; i++) push(32'hC000_0000 + 32'(i), 6'(i % 4), 1'b1);
        check("pp_pre_count", 64'(count), 64'd3);
        spacing_en = 1'b1;
        begin
            int n = 0;
            while (cyc != last_pulse_cyc + GAP && n < 100) begin
                @(negedge pclk);
                n++;
            end
        end
        check("pp_align", 64'(cyc - last_pulse_cyc), 64'(GAP));
        push(32'hC000_0004, 6'd0, 1'b1);
        check("pp_count", 64'(count), 64'd3);
        check("pp_mv", 64'(master_valid), 64'd1);
        for (int i = 5; i < 20; i++) push(32'hC000_0000 + 32'(i), 6'(i % 4), 1'b1);
        wait_drain();

        // Out-of-range destination.
`ifdef APB_QUEUE_ADDR_CHECK_EN
        push(32'h5555_0005, 6'd5, 1'b0);
        check("bad_aerr", 64'(addr_err), 64'd1);
        check("bad_ecnt", 64'(err_count), 64'd1);
        check("bad_count", 64'(count), 64'd0);
        @(negedge pclk);
        check("bad_aerr_end", 64'(addr_err), 64'd0);
        repeat (50) @(negedge pclk);
        for (int i = 0; i < 300; i++) push(32'(i), 6'd5, 1'b0);
        @(negedge pclk);
        check("sat_ecnt", 64'(err_count), 64'd255);
        check("sat_count", 64'(count), 64'd0);
        repeat (50) @(negedge pclk);
`else
        push(32'h5555_0005, 6'd5, 1'b1);
        check("bad_aerr", 64'(addr_err), 64'd0);
        check("bad_ecnt", 64'(err_count), 64'd0);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
